// File: rtl/arb_mux_pkg.sv
// Shared types for the round-robin arbitrating mux.
// Holds the control FSM state encoding and the select-width derivation.
package arb_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_mux_rr_pick.sv
// Round-robin picker: first requesting index at or above ptr, wrapping at NUM_IN-1.
// Purely combinational, zero latency, no backpressure of its own.
module rr_pick
    import arb_mux_pkg::*;
#(
    parameter int NUM_IN    = 4,
    parameter int SEL_WIDTH = sel_width(NUM_IN)
) (
    input  logic [NUM_IN-1:0]    req,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic [SEL_WIDTH-1:0] grant,
    output logic                 any_req
);

    // Walk from farthest offset to nearest so the nearest requester wins.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NUM_IN]) begin
                grant   = SEL_WIDTH'((int'(ptr) + i) % NUM_IN);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// Round-robin N:1 mux with transaction locking and a single registered output stage.
// Latency 1 cycle accept-to-output; in_ready withheld while the output register is full and stalled.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 4,
    localparam int SEL_WIDTH = sel_width(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN-1:0]            in_valid,
    output logic [NUM_IN-1:0]            in_ready,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_last,
    output logic [SEL_WIDTH-1:0]         out_sel
);

    state_t                 state_q, state_d;
    logic [SEL_WIDTH-1:0]   ptr_q, ptr_d;
    logic [SEL_WIDTH-1:0]   pick_grant;
    logic [SEL_WIDTH-1:0]   grant;
    logic                   any_req;
    logic                   load_ok;
    logic                   accept;
    logic                   acc_last;

    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic                   out_last_q, out_last_d;
    logic [SEL_WIDTH-1:0]   out_sel_q, out_sel_d;

    logic [DATA_WIDTH-1:0]  chan_dat [NUM_IN];

    for (genvar k = 0; k < NUM_IN; k++) begin : g_chan
        assign chan_dat[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_IN    (NUM_IN),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_pick (
        .req     (in_valid),
        .ptr     (ptr_q),
        .grant   (pick_grant),
        .any_req (any_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = acc_last ? IDLE : LOCKED;
        end
    end

    // While locked, out_sel_q still names the locked channel: it only moves on acceptance.
    always_comb begin
        grant    = (state_q == LOCKED) ? out_sel_q : pick_grant;
        load_ok  = !out_valid_q || out_ready;
        accept   = !rst && load_ok &&
                   ((state_q == LOCKED) ? in_valid[grant] : any_req);
        acc_last = in_last[grant];
        in_ready = '0;
        if (accept) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = chan_dat[grant];
            out_last_d  = acc_last;
            out_sel_d   = grant;
            if (acc_last) begin
                ptr_d = (grant == SEL_WIDTH'(NUM_IN - 1)) ? '0 : grant + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: directed scenarios on 4- and 3-input instances plus randomized
// traffic against a transaction-level round-robin model with per-channel scoreboards.
module tb_arb_mux;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]   v4, l4, r4;
    logic [127:0] d4;
    logic         ov4, ordy4, ol4;
    logic [31:0]  od4;
    logic [1:0]   os4;

    logic [2:0]   v3, l3, r3;
    logic [95:0]  d3;
    logic         ov3, ordy3, ol3;
    logic [31:0]  od3;
    logic [1:0]   os3;

    arb_mux #(.DATA_WIDTH(32), .NUM_IN(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .in_data(d4), .in_last(l4),
        .out_valid(ov4), .out_ready(ordy4), .out_data(od4), .out_last(ol4), .out_sel(os4)
    );

    arb_mux #(.DATA_WIDTH(32), .NUM_IN(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(r3), .in_data(d3), .in_last(l3),
        .out_valid(ov3), .out_ready(ordy3), .out_data(od3), .out_last(ol3), .out_sel(os3)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state for the 4-input instance
    int          m_ptr, m_lock, m_os;
    logic        m_ov, m_ol;
    logic [31:0] m_od;
    logic [31:0] exp_q [4][$];
    logic [31:0] sdat [4];
    logic        sv [4];
    logic        sl [4];
    int          sseq [4];
    int          wait_cnt [4];

    function automatic int model_grant(input logic [3:0] v);
        if (m_lock >= 0) return v[m_lock] ? m_lock : -1;
        for (int i = 0; i < 4; i++) begin
            if (v[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
        end
        return -1;
    endfunction

    task automatic set4(input int c, input logic [31:0] d);
        d4[c*32 +: 32] = d;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        v4 = '0; l4 = '0; d4 = '0; ordy4 = 1'b1;
        v3 = '0; l3 = '0; d3 = '0; ordy3 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        v4 = 4'hF; l4 = 4'hF; d4 = {$urandom, $urandom, $urandom, $urandom}; ordy4 = 1'b1;
        v3 = 3'h7; l3 = 3'h7; d3 = '0; ordy3 = 1'b1;
        #2;
        n_vec++; if (ov4 !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", ov4); end
        n_vec++; if (od4 !== 32'h0) begin n_err++; $display("FAIL rst_out_data: got %h want 0", od4); end
        n_vec++; if (ol4 !== 1'b0) begin n_err++; $display("FAIL rst_out_last: got %b want 0", ol4); end
        n_vec++; if (os4 !== 2'd0) begin n_err++; $display("FAIL rst_out_sel: got %0d want 0", os4); end
        n_vec++; if (r4 !== 4'b0) begin n_err++; $display("FAIL rst_in_ready4: got %b want 0000", r4); end
        n_vec++; if (r3 !== 3'b0) begin n_err++; $display("FAIL rst_in_ready3: got %b want 000", r3); end
        @(posedge clk); #1;
        n_vec++; if (ov4 !== 1'b0 || r4 !== 4'b0) begin n_err++; $display("FAIL rst_held: got ov=%b rdy=%b want 0/0000", ov4, r4); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++; if (r4 !== 4'b0001) begin n_err++; $display("FAIL rst_release_grant: got %b want 0001", r4); end
    endtask

    task automatic test_round_robin;
        do_reset;
        v4 = 4'hF; l4 = 4'hF; ordy4 = 1'b1;
        for (int k = 0; k < 4; k++) set4(k, 32'hA000_0000 + k);
        #1;
        n_vec++; if (r4 !== 4'b0001) begin n_err++; $display("FAIL rr_first_ready: got %b want 0001", r4); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (ov4 !== 1'b1 || os4 !== 2'(i % 4) || od4 !== 32'hA000_0000 + 32'(i % 4)) begin
                n_err++;
                $display("FAIL rr_seq[%0d]: got v=%b sel=%0d data=%h want v=1 sel=%0d", i, ov4, os4, od4, i % 4);
            end
        end
        v4 = '0;
    endtask

    task automatic test_lock;
        do_reset;
        ordy4 = 1'b1; v4 = 4'b0100; l4 = 4'b0000; set4(2, 32'hB000_0001);
        #1;
        n_vec++; if (r4 !== 4'b0100) begin n_err++; $display("FAIL lock_first_rdy: got %b want 0100", r4); end
        @(posedge clk); #1;
        n_vec++; if (os4 !== 2'd2 || od4 !== 32'hB000_0001) begin n_err++; $display("FAIL lock_beat1: got sel=%0d data=%h want 2/b0000001", os4, od4); end
        v4 = 4'b0101; set4(2, 32'hB000_0002); set4(0, 32'hC000_0000);
        #1;
        n_vec++; if (r4 !== 4'b0100) begin n_err++; $display("FAIL lock_hold_rdy: got %b want 0100", r4); end
        @(posedge clk); #1;
        n_vec++; if (os4 !== 2'd2 || od4 !== 32'hB000_0002) begin n_err++; $display("FAIL lock_beat2: got sel=%0d data=%h want 2/b0000002", os4, od4); end
        v4 = 4'b0001;
        #1;
        n_vec++; if (r4 !== 4'b0000) begin n_err++; $display("FAIL lock_bubble_rdy: got %b want 0000", r4); end
        @(posedge clk); #1;
        n_vec++; if (ov4 !== 1'b0) begin n_err++; $display("FAIL lock_bubble_out: got %b want 0", ov4); end
        v4 = 4'b0101; l4 = 4'b0100; set4(2, 32'hB000_0003);
        #1;
        n_vec++; if (r4 !== 4'b0100) begin n_err++; $display("FAIL lock_last_rdy: got %b want 0100", r4); end
        @(posedge clk); #1;
        n_vec++; if (os4 !== 2'd2 || od4 !== 32'hB000_0003 || ol4 !== 1'b1) begin n_err++; $display("FAIL lock_beat3: got sel=%0d data=%h last=%b want 2/b0000003/1", os4, od4, ol4); end
        v4 = 4'b0001; l4 = 4'b0001;
        #1;
        n_vec++; if (r4 !== 4'b0001) begin n_err++; $display("FAIL lock_release_rdy: got %b want 0001", r4); end
        @(posedge clk); #1;
        n_vec++; if (os4 !== 2'd0 || od4 !== 32'hC000_0000) begin n_err++; $display("FAIL lock_next_ch0: got sel=%0d data=%h want 0/c0000000", os4, od4); end
        v4 = '0;
    endtask

    task automatic test_backpressure;
        do_reset;
        ordy4 = 1'b1; v4 = 4'b0010; l4 = 4'hF; set4(1, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        n_vec++; if (ov4 !== 1'b1 || od4 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL bp_load: got v=%b data=%h want 1/deadbeef", ov4, od4); end
        ordy4 = 1'b0; v4 = 4'b1010; set4(1, 32'h1111_1111); set4(3, 32'h3333_3333);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++; if (r4 !== 4'b0000) begin n_err++; $display("FAIL bp_rdy[%0d]: got %b want 0000", i, r4); end
            @(posedge clk); #1;
            n_vec++;
            if (ov4 !== 1'b1 || od4 !== 32'hDEAD_BEEF || os4 !== 2'd1) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got v=%b data=%h sel=%0d want 1/deadbeef/1", i, ov4, od4, os4);
            end
        end
        ordy4 = 1'b1;
        #1;
        n_vec++; if (r4 !== 4'b1000) begin n_err++; $display("FAIL bp_release_rdy: got %b want 1000", r4); end
        @(posedge clk); #1;
        n_vec++; if (od4 !== 32'h3333_3333 || os4 !== 2'd3) begin n_err++; $display("FAIL bp_after1: got data=%h sel=%0d want 33333333/3", od4, os4); end
        v4 = 4'b0010;
        #1;
        n_vec++; if (r4 !== 4'b0010) begin n_err++; $display("FAIL bp_wrap_rdy: got %b want 0010", r4); end
        @(posedge clk); #1;
        n_vec++; if (od4 !== 32'h1111_1111 || os4 !== 2'd1) begin n_err++; $display("FAIL bp_after2: got data=%h sel=%0d want 11111111/1", od4, os4); end
        v4 = '0;
        #1;
        n_vec++; if (r4 !== 4'b0000) begin n_err++; $display("FAIL bp_idle_rdy: got %b want 0000", r4); end
        @(posedge clk); #1;
        n_vec++; if (ov4 !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b want 0", ov4); end
    endtask

    task automatic test_wrap3;
        do_reset;
        ordy3 = 1'b1; v3 = 3'b110; l3 = 3'b111;
        d3[32 +: 32] = 32'h0000_0C01;
        d3[64 +: 32] = 32'h0000_0C02;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (os3 !== ((i % 2) ? 2'd2 : 2'd1) || od3 !== ((i % 2) ? 32'h0C02 : 32'h0C01) || ov3 !== 1'b1) begin
                n_err++;
                $display("FAIL wrap3[%0d]: got v=%b sel=%0d data=%h want sel=%0d", i, ov3, os3, od3, (i % 2) ? 2 : 1);
            end
        end
        v3 = '0;
    endtask

    task automatic test_reset_midlock;
        do_reset;
        ordy4 = 1'b1; v4 = 4'b1000; l4 = 4'b0000; set4(3, 32'hD000_0001);
        @(posedge clk); #1;
        n_vec++; if (os4 !== 2'd3) begin n_err++; $display("FAIL ml_beat1: got sel=%0d want 3", os4); end
        set4(3, 32'hD000_0002); set4(0, 32'hE000_0000); v4 = 4'b1001;
        #1;
        n_vec++; if (r4 !== 4'b1000) begin n_err++; $display("FAIL ml_locked_rdy: got %b want 1000", r4); end
        @(posedge clk); #1;
        n_vec++; if (ov4 !== 1'b1 || od4 !== 32'hD000_0002) begin n_err++; $display("FAIL ml_beat2: got v=%b data=%h want 1/d0000002", ov4, od4); end
        rst = 1'b1;
        #1;
        n_vec++;
        if (ov4 !== 1'b0 || r4 !== 4'b0 || os4 !== 2'd0 || od4 !== 32'h0) begin
            n_err++;
            $display("FAIL ml_async_rst: got v=%b rdy=%b sel=%0d data=%h want 0/0000/0/0", ov4, r4, os4, od4);
        end
        @(negedge clk);
        rst = 1'b0;
        set4(3, 32'hD000_0003);
        #1;
        n_vec++; if (r4 !== 4'b0001) begin n_err++; $display("FAIL ml_restart_rdy: got %b want 0001", r4); end
        @(posedge clk); #1;
        n_vec++; if (os4 !== 2'd0 || od4 !== 32'hE000_0000) begin n_err++; $display("FAIL ml_restart_out: got sel=%0d data=%h want 0/e0000000", os4, od4); end
        v4 = '0;
    endtask

    task automatic test_random(input int cycles);
        int          g;
        int          ch;
        logic [3:0]  er;
        logic        acc;
        logic [31:0] popped;
        do_reset;
        m_ptr = 0; m_lock = -1; m_ov = 1'b0; m_ol = 1'b0; m_od = '0; m_os = 0;
        for (int c = 0; c < 4; c++) begin
            exp_q[c].delete();
            sseq[c] = 0;
            sdat[c] = {4'(c), 28'd0};
            sl[c] = ($urandom % 3) == 0;
            sv[c] = 1'b0;
            wait_cnt[c] = 0;
        end
        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(posedge clk); #1;
            n_vec++; if (ov4 !== m_ov) begin n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, ov4, m_ov); end
            if (m_ov) begin
                n_vec++;
                if (od4 !== m_od || ol4 !== m_ol || os4 !== 2'(m_os)) begin
                    n_err++;
                    $display("FAIL rnd_out@%0d: got %h/%b/%0d want %h/%b/%0d", cyc, od4, ol4, os4, m_od, m_ol, m_os);
                end
            end
            for (int c = 0; c < 4; c++) begin
                if (!sv[c] && ($urandom % 2) == 1) sv[c] = 1'b1;
                v4[c] = sv[c];
                l4[c] = sl[c];
                set4(c, sdat[c]);
            end
            ordy4 = ($urandom % 10) < 7;
            #1;
            g   = model_grant(v4);
            acc = (g >= 0) && (!m_ov || ordy4);
            er  = '0;
            if (acc) er[g] = 1'b1;
            n_vec++; if (r4 !== er) begin n_err++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, r4, er); end
            if (ov4 === 1'b1 && ordy4) begin
                ch = int'(os4);
                n_vec++;
                if (exp_q[ch].size() == 0) begin
                    n_err++;
                    $display("FAIL rnd_sb_extra@%0d: got ch%0d data %h want no beat", cyc, ch, od4);
                end else begin
                    popped = exp_q[ch].pop_front();
                    if (od4 !== popped) begin
                        n_err++;
                        $display("FAIL rnd_sb_order@%0d: got %h want %h", cyc, od4, popped);
                    end
                end
            end
            if (acc) begin
                exp_q[g].push_back(sdat[g]);
                m_ov = 1'b1; m_od = sdat[g]; m_ol = sl[g]; m_os = g;
                wait_cnt[g] = 0;
                if (sl[g]) begin
                    m_ptr = (g + 1) % 4;
                    m_lock = -1;
                    for (int c = 0; c < 4; c++) begin
                        if (c != g && sv[c]) begin
                            wait_cnt[c]++;
                            n_vec++;
                            if (wait_cnt[c] > 3) begin
                                n_err++;
                                $display("FAIL rnd_starve@%0d: got ch%0d waited %0d txns want <=3", cyc, c, wait_cnt[c]);
                            end
                        end
                    end
                end else begin
                    m_lock = g;
                end
                sseq[g]++;
                sdat[g] = {4'(g), 28'(sseq[g])};
                sl[g] = ($urandom % 3) == 0;
                sv[g] = ($urandom % 4) != 0;
            end else if (ordy4) begin
                m_ov = 1'b0;
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            v4 = '0; ordy4 = 1'b1;
            #1;
            if (ov4 === 1'b1) begin
                ch = int'(os4);
                n_vec++;
                if (exp_q[ch].size() == 0) begin
                    n_err++;
                    $display("FAIL rnd_drain_extra: got ch%0d data %h want no beat", ch, od4);
                end else begin
                    popped = exp_q[ch].pop_front();
                    if (od4 !== popped) begin
                        n_err++;
                        $display("FAIL rnd_drain_order: got %h want %h", od4, popped);
                    end
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            n_vec++;
            if (exp_q[c].size() != 0) begin
                n_err++;
                $display("FAIL rnd_complete ch%0d: got %0d beats undelivered want 0", c, exp_q[c].size());
            end
        end
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_lock;
        test_backpressure;
        test_wrap3;
        test_reset_midlock;
        test_random(4000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
